// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencer (lw/sw/R/I/beq/jal) for a shared instruction/data memory port.
// Optional MC_PERF_CNT_EN adds cycle and retired-instruction counters.
module mc_control_fsm #(
`ifdef MC_PERF_CNT_EN
  parameter int unsigned CNT_W = 32,
`endif
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic        illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    sIdle, sFetch, sDecode, sMemAdr, sMemRead, sMemWb, sMemWrite,
    sExecR, sExecI, sAluWb, sBeq, sJal, sTrap
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  stateT       state;
  stateT       stateNext;
  logic [6:0]  opcode;
  logic        opKnown;
  logic [1:0]  immSel;
  logic [2:0]  functAlu;
  logic        unusedInstrBits;

  assign opcode          = instr[6:0];
  assign opKnown         = opcode inside {OP_LOAD, OP_STORE, OP_RALU, OP_IALU, OP_BRANCH, OP_JAL};
  assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= sIdle;
      illegal <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == sDecode && !opKnown) illegal <= 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      sIdle:     stateNext = sFetch;
      sFetch:    if (mem_ready) stateNext = sDecode;
      sDecode: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: stateNext = sMemAdr;
          OP_RALU:           stateNext = sExecR;
          OP_IALU:           stateNext = sExecI;
          OP_BRANCH:         stateNext = sBeq;
          OP_JAL:            stateNext = sJal;
          default:           stateNext = TRAP_ON_ILLEGAL ? sTrap : sFetch;
        endcase
      end
      sMemAdr:   stateNext = opcode[5] ? sMemWrite : sMemRead;
      sMemRead:  if (mem_ready) stateNext = sMemWb;
      sMemWb:    stateNext = sFetch;
      sMemWrite: if (mem_ready) stateNext = sFetch;
      sExecR,
      sExecI:    stateNext = sAluWb;
      sAluWb:    stateNext = sFetch;
      sBeq:      stateNext = sFetch;
      sJal:      stateNext = sAluWb;
      sTrap:     stateNext = sTrap;
      default:   stateNext = sIdle;
    endcase
  end

  always_comb begin
    immSel = 2'b00;
    unique case (opcode)
      OP_STORE:  immSel = 2'b01;
      OP_BRANCH: immSel = 2'b10;
      OP_JAL:    immSel = 2'b11;
      default:   immSel = 2'b00;
    endcase
  end

  // f7[5] only selects sub for register-register ops; addi with that bit set stays add
  always_comb begin
    functAlu = ALU_ADD;
    unique case (instr[14:12])
      3'b000:  functAlu = (opcode[5] && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  functAlu = ALU_SLT;
      3'b110:  functAlu = ALU_OR;
      3'b111:  functAlu = ALU_AND;
      default: functAlu = ALU_ADD;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    if (state != sIdle && state != sTrap) imm_src = immSel;
    unique case (state)
      sFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      sDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      sMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      sMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      sMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      sMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      sExecR: begin
        alu_src_a   = 2'b10;
        alu_control = functAlu;
      end
      sExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = functAlu;
      end
      sAluWb: reg_write = 1'b1;
      sBeq: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      sJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != sIdle && state != sTrap) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stateNext == sFetch && state != sFetch && state != sIdle)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (illegal opcode retired as NOP / trapped) checked
// every cycle against a phase-queue model, plus directed latency and reset cases.
module tb_mc_control_fsm;

  localparam int unsigned CW = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        memReady;

  logic       mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0, illegal0;
  logic [1:0] alu_src_a0, alu_src_b0, result_src0, imm_src0;
  logic [2:0] alu_control0;
  logic       mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1, illegal1;
  logic [1:0] alu_src_a1, alu_src_b1, result_src1, imm_src1;
  logic [2:0] alu_control1;
`ifdef MC_PERF_CNT_EN
  logic [CW-1:0] cycCnt0, insCnt0, cycCnt1, insCnt1;
`endif

  mc_control_fsm #(
`ifdef MC_PERF_CNT_EN
    .CNT_W(CW),
`endif
    .TRAP_ON_ILLEGAL(1'b0)
  ) dutNop (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(memReady),
    .mem_req(mem_req0), .mem_write(mem_write0), .adr_src(adr_src0), .ir_write(ir_write0),
    .pc_write(pc_write0), .reg_write(reg_write0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .result_src(result_src0), .imm_src(imm_src0), .alu_control(alu_control0), .illegal(illegal0)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycCnt0), .instret_cnt(insCnt0)
`endif
  );

  mc_control_fsm #(
`ifdef MC_PERF_CNT_EN
    .CNT_W(CW),
`endif
    .TRAP_ON_ILLEGAL(1'b1)
  ) dutTrap (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(memReady),
    .mem_req(mem_req1), .mem_write(mem_write1), .adr_src(adr_src1), .ir_write(ir_write1),
    .pc_write(pc_write1), .reg_write(reg_write1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .result_src(result_src1), .imm_src(imm_src1), .alu_control(alu_control1), .illegal(illegal1)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycCnt1), .instret_cnt(insCnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each instruction is a list of phases; memory phases stall while mem_ready is low.
  typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_RD, P_WBMEM, P_WR, P_EXR, P_EXI, P_WBALU, P_BR, P_JL} phaseT;

  phaseT         q[$];
  bit            mIdle, mTrap1, mIll;
  logic [CW-1:0] mCyc0, mIns0, mCyc1, mIns1;
  int unsigned   checks, errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    phaseT cur;
    if (!rst_n) begin
      mIdle = 1'b1; mTrap1 = 1'b0; mIll = 1'b0; q.delete();
      mCyc0 = '0; mIns0 = '0; mCyc1 = '0; mIns1 = '0;
    end else if (mIdle) begin
      mIdle = 1'b0;
      q.push_back(P_FETCH);
    end else begin
      mCyc0 = mCyc0 + 1'b1;
      if (!mTrap1) mCyc1 = mCyc1 + 1'b1;
      if (!(q[0] inside {P_FETCH, P_RD, P_WR} && !memReady)) begin
        cur = q.pop_front();
        if (cur == P_FETCH) q.push_back(P_DECODE);
        if (cur == P_DECODE) begin
          case (instr[6:0])
            7'b0000011: begin q.push_back(P_ADDR); q.push_back(P_RD); q.push_back(P_WBMEM); end
            7'b0100011: begin q.push_back(P_ADDR); q.push_back(P_WR); end
            7'b0110011: begin q.push_back(P_EXR); q.push_back(P_WBALU); end
            7'b0010011: begin q.push_back(P_EXI); q.push_back(P_WBALU); end
            7'b1100011: q.push_back(P_BR);
            7'b1101111: begin q.push_back(P_JL); q.push_back(P_WBALU); end
            default: begin mIll = 1'b1; mTrap1 = 1'b1; end
          endcase
        end
        if (q.size() == 0) begin
          q.push_back(P_FETCH);
          mIns0 = mIns0 + 1'b1;
          if (!mTrap1) mIns1 = mIns1 + 1'b1;
        end
      end
    end
  endtask

  function automatic logic [17:0] expFor(input phaseT p, input logic [31:0] ins, input logic z,
                                         input logic rdy, input logic ill);
    logic mreq, mwr, adr, irw, pcw, rw;
    logic [1:0] a, b, rs, imm;
    logic [2:0] alu, f;
    mreq = 0; mwr = 0; adr = 0; irw = 0; pcw = 0; rw = 0;
    a = 2'b00; b = 2'b00; rs = 2'b00; alu = 3'b000;
    case (ins[6:0])
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (ins[14:12])
      3'b000:  f = (ins[5] && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  f = 3'b101;
      3'b110:  f = 3'b011;
      3'b111:  f = 3'b010;
      default: f = 3'b000;
    endcase
    case (p)
      P_FETCH:  begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE: begin a = 2'b01; b = 2'b01; end
      P_ADDR:   begin a = 2'b10; b = 2'b01; end
      P_RD:     begin mreq = 1; adr = 1; end
      P_WBMEM:  begin rs = 2'b01; rw = 1; end
      P_WR:     begin mreq = 1; mwr = 1; adr = 1; end
      P_EXR:    begin a = 2'b10; alu = f; end
      P_EXI:    begin a = 2'b10; b = 2'b01; alu = f; end
      P_WBALU:  rw = 1;
      P_BR:     begin a = 2'b10; alu = 3'b001; pcw = z; end
      P_JL:     begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rw, a, b, rs, imm, alu, ill};
  endfunction

  task automatic cmpModel();
    logic [17:0] e0, e1, a0, a1;
    a0 = {mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0,
          alu_src_a0, alu_src_b0, result_src0, imm_src0, alu_control0, illegal0};
    a1 = {mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1,
          alu_src_a1, alu_src_b1, result_src1, imm_src1, alu_control1, illegal1};
    if (!rst_n || mIdle) begin
      e0 = '0; e1 = '0;
    end else begin
      e0 = expFor(q[0], instr, zero, memReady, mIll);
      e1 = mTrap1 ? 18'd1 : e0;
    end
    chk("outsNop", 32'(a0), 32'(e0));
    chk("outsTrap", 32'(a1), 32'(e1));
`ifdef MC_PERF_CNT_EN
    chk("cycNop",  32'(cycCnt0), rst_n ? 32'(mCyc0) : 32'd0);
    chk("insNop",  32'(insCnt0), rst_n ? 32'(mIns0) : 32'd0);
    chk("cycTrap", 32'(cycCnt1), rst_n ? 32'(mCyc1) : 32'd0);
    chk("insTrap", 32'(insCnt1), rst_n ? 32'(mIns1) : 32'd0);
`endif
  endtask

  // Every posedge goes through toPos so the model never misses an edge.
  task automatic toPos();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
    cmpModel();
  endtask

  task automatic cycle();
    toNeg();
    toPos();
  endtask

  // Runs one instruction from FETCH back to FETCH on the NOP instance; entered at posedge+1 in FETCH.
  task automatic runOne(input logic [31:0] ins, input int unsigned waitF, input int unsigned waitM,
                        input logic z, output int unsigned cyc, output int unsigned irw,
                        output int unsigned regw, output int unsigned pcw, output logic [2:0] aluX);
    int unsigned fw, mw;
    bit left;
    fw = 0; mw = 0; left = 0; cyc = 0; irw = 0; regw = 0; pcw = 0; aluX = 3'bxxx;
    instr = ins;
    do begin
      memReady = 1'b1;
      if (q[0] == P_FETCH && fw < waitF) begin memReady = 1'b0; fw++; end
      if (q[0] inside {P_RD, P_WR} && mw < waitM) begin memReady = 1'b0; mw++; end
      zero = z;
      if (q[0] inside {P_EXR, P_EXI, P_BR}) aluX = alu_control0;
      toNeg();
      cyc++;
      irw  += 32'(ir_write0);
      regw += 32'(reg_write0);
      pcw  += 32'(pc_write0);
      toPos();
      if (q[0] != P_FETCH) left = 1;
    end while (!(left && q[0] == P_FETCH) && cyc < 40);
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0] ops [7];
    logic [6:0] bad [6];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110011};
    bad = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h0F};
    r = $urandom;
    if ($urandom_range(19) == 0) r[6:0] = bad[$urandom_range(5)];
    else                         r[6:0] = ops[$urandom_range(6)];
    return r;
  endfunction

  initial begin
    int unsigned cyc, irw, regw, pcw;
    logic [2:0]  aluX;
    checks = 0; errors = 0;
    instr = 32'h0; zero = 1'b0; memReady = 1'b0;
    mIdle = 1'b1; mTrap1 = 1'b0; mIll = 1'b0;
    mCyc0 = '0; mIns0 = '0; mCyc1 = '0; mIns1 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    toNeg();
    chk("rstMemReq", 32'(mem_req0), 32'd0);
    chk("rstIllegal", 32'(illegal1), 32'd0);
    toPos();
    rst_n = 1'b1;
    toNeg();
    chk("idleMemReq", 32'(mem_req0), 32'd0);
    toPos();

`ifdef MC_PERF_CNT_EN
    memReady = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    toNeg();
    chk("cycAt15", 32'(cycCnt0), 32'd15);
    toPos();
    toNeg();
    chk("cycWrap", 32'(cycCnt0), 32'd0);
    toPos();
`endif

    runOne(32'h002081B3, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("addCycles", cyc, 32'd4);
    chk("addRegWrite", regw, 32'd1);
    chk("addAlu", 32'(aluX), 32'd0);
    runOne(32'h402081B3, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("subAlu", 32'(aluX), 32'd1);
    runOne(32'h0020A1B3, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("sltAlu", 32'(aluX), 32'd5);
    runOne(32'h40008093, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("addiF7Alu", 32'(aluX), 32'd0);
    chk("addiCycles", cyc, 32'd4);
    runOne(32'h0000A183, 3, 3, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("lwWaitCycles", cyc, 32'd11);
    chk("lwIrWrite", irw, 32'd1);
    chk("lwRegWrite", regw, 32'd1);
    runOne(32'h0030A023, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("swCycles", cyc, 32'd4);
    chk("swRegWrite", regw, 32'd0);
    runOne(32'h00208463, 0, 0, 1'b1, cyc, irw, regw, pcw, aluX);
    chk("beqTakenCycles", cyc, 32'd3);
    chk("beqTakenPcWrite", pcw, 32'd2);
    runOne(32'h00208463, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("beqNotTakenPcWrite", pcw, 32'd1);
    runOne(32'h008000EF, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("jalCycles", cyc, 32'd4);
    chk("jalPcWrite", pcw, 32'd2);
    chk("jalRegWrite", regw, 32'd1);
    runOne(32'h0000007F, 0, 0, 1'b0, cyc, irw, regw, pcw, aluX);
    chk("illegalNopCycles", cyc, 32'd2);
    instr = 32'h002081B3;
    for (int i = 0; i < 4; i++) begin
      memReady = 1'b1;
      toNeg();
      chk("trapMemReq", 32'(mem_req1), 32'd0);
      chk("trapIllegal", 32'(illegal1), 32'd1);
      chk("nopIllegalSticky", 32'(illegal0), 32'd1);
      toPos();
    end

    // asynchronous reset while a store is waiting on memory
    instr = 32'h0030A023;
    for (int k = 0; k < 10 && q[0] != P_WR; k++) begin
      memReady = 1'b1;
      cycle();
    end
    memReady = 1'b0;
    toNeg();
    chk("preRstMemWrite", 32'(mem_write0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("asyncRstMemReq", 32'(mem_req0), 32'd0);
    chk("asyncRstMemWrite", 32'(mem_write0), 32'd0);
`ifdef MC_PERF_CNT_EN
    chk("asyncRstCyc", 32'(cycCnt0), 32'd0);
    chk("asyncRstIns", 32'(insCnt0), 32'd0);
`endif
    toPos();
    rst_n = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      if (mIdle || q[0] == P_FETCH) instr = randInstr();
      memReady = ($urandom_range(9) < 6);
      zero     = 1'($urandom_range(1));
      if ($urandom_range(99) == 0) begin
        #2 rst_n = 1'b0;
        toNeg();
        toPos();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
